led_pattern_gen: RTL and testbench

Parametrised LED pattern generator: successor to the fixed 8-bit rotating-one LED driver. Drives a WIDTH-bit LED bank with a selectable pattern (rotate, ping-pong, fill/drain bar, Johnson) advanced by a built-in programmable prescaler, with parallel load and end-of-pattern strobes. Sits between the board clock and the LED pins; control inputs come from switches or a host register block.

---
 rtl/led_pattern_gen.sv | 133 +++++++++++++
 tb/tb_led_pattern_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern generator: rotate, ping-pong, fill/drain bar and Johnson
// patterns stepped by a programmable prescaler, with parallel load and strobes.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_ROTATE   = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_FILL     = 2'b10,
        MODE_JOHNSON  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] LED_SEED = WIDTH'(1);
    localparam logic [WIDTH-1:0] LED_ONES = '1;
    localparam logic [WIDTH-1:0] LED_ZERO = '0;

    mode_e            mode_in;
    mode_e            mode_q;
    logic [DIV_W-1:0] cnt;
    logic             up;

    logic [WIDTH-1:0] step_led;
    logic             step_up;
    logic             step_wrap;

    assign mode_in = mode_e'(mode);

    // Next pattern value if a step were taken this edge; the register decides whether to use it.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        step_led  = led;
        step_up   = up;
        step_wrap = 1'b0;
        unique case (mode_q)
            MODE_ROTATE: begin
                if (dir) begin
                    step_led  = {led[WIDTH-2:0], led[WIDTH-1]};
                    step_wrap = led[WIDTH-1];
                end else begin
                    step_led  = {led[0], led[WIDTH-1:1]};
                    step_wrap = led[0];
                end
            end
            MODE_PINGPONG: begin
                if (up) begin
                    step_led = led << 1;
                    if (step_led[WIDTH-1]) begin
                        step_up   = 1'b0;
                        step_wrap = 1'b1;
                    end
                end else begin
                    step_led = led >> 1;
                    if (step_led[0]) begin
                        step_up   = 1'b1;
                        step_wrap = 1'b1;
                    end
                end
            end
            MODE_FILL: begin
                if (up) begin
                    step_led = {led[WIDTH-2:0], 1'b1};
                    if (step_led == LED_ONES) begin
                        step_up   = 1'b0;
                        step_wrap = 1'b1;
                    end
                end else begin
                    step_led = led >> 1;
                    if (step_led <= LED_SEED) begin
                        step_up   = 1'b1;
                        step_wrap = 1'b1;
                    end
                end
            end
            MODE_JOHNSON: begin
                if (dir) step_led = {led[WIDTH-2:0], ~led[WIDTH-1]};
                else     step_led = {~led[0], led[WIDTH-1:1]};
                step_wrap = (step_led == LED_ZERO);
            end
            default: ;
        endcase
    end

    // Reset also samples mode so the first edge afterwards is not seen as a mode change.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            led    <= LED_SEED;
            cnt    <= '0;
            up     <= 1'b1;
            tick   <= 1'b0;
            wrap   <= 1'b0;
            mode_q <= mode_in;
        end else begin
            tick   <= 1'b0;
            wrap   <= 1'b0;
            mode_q <= mode_in;
            if (mode_in != mode_q) begin
                led <= LED_SEED;
                up  <= 1'b1;
                cnt <= '0;
            end else if (load) begin
                led <= load_val;
                up  <= 1'b1;
                cnt <= '0;
            end else if (!en) begin
                cnt <= '0;
            end else if (cnt >= div) begin
                led  <= step_led;
                up   <= step_up;
                wrap <= step_wrap;
                tick <= 1'b1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed vectors with literal expectations plus an
// arithmetic reference model compared against the DUT on every cycle.
module tb_led_pattern_gen;

    localparam int WIDTH = 8;
    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] led;
    logic             tick;
    logic             wrap;

    always #5 clk = ~clk;

    led_pattern_gen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .div(div),
        .load(load), .load_val(load_val), .led(led), .tick(tick), .wrap(wrap)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {led,tick,wrap}=%0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: LEDs held as an integer, patterns computed with plain arithmetic.
    int         m_led;
    int         m_cnt;
    bit         m_up;
    bit         m_tick;
    bit         m_wrap;
    bit         model_on = 1'b0;
    logic [1:0] m_mode;

    function automatic void model_step();
        int out_bit;
        case (m_mode)
            2'd0: begin
                if (dir) begin
                    out_bit = m_led / 128;
                    m_led   = ((m_led * 2) % 256) + out_bit;
                end else begin
                    out_bit = m_led % 2;
                    m_led   = (m_led / 2) + out_bit * 128;
                end
                m_wrap = (out_bit == 1);
            end
            2'd1: begin
                if (m_up) begin
                    m_led = (m_led * 2) % 256;
                    if (m_led >= 128) begin m_up = 1'b0; m_wrap = 1'b1; end
                end else begin
                    m_led = m_led / 2;
                    if (m_led % 2 == 1) begin m_up = 1'b1; m_wrap = 1'b1; end
                end
            end
            2'd2: begin
                if (m_up) begin
                    m_led = (m_led * 2 + 1) % 256;
                    if (m_led == 255) begin m_up = 1'b0; m_wrap = 1'b1; end
                end else begin
                    m_led = m_led / 2;
                    if (m_led <= 1) begin m_up = 1'b1; m_wrap = 1'b1; end
                end
            end
            default: begin
                if (dir) m_led = (m_led * 2) % 256 + ((m_led >= 128) ? 0 : 1);
                else     m_led = m_led / 2 + ((m_led % 2 == 1) ? 0 : 128);
                m_wrap = (m_led == 0);
            end
        endcase
    endfunction

    always @(posedge clk) begin
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (rst) begin
            m_led = 1; m_cnt = 0; m_up = 1'b1; model_on = 1'b1;
        end else if (mode != m_mode) begin
            m_led = 1; m_cnt = 0; m_up = 1'b1;
        end else if (load) begin
            m_led = int'(load_val); m_cnt = 0; m_up = 1'b1;
        end else if (!en) begin
            m_cnt = 0;
        end else if (m_cnt >= int'(div)) begin
            m_cnt  = 0;
            m_tick = 1'b1;
            model_step();
        end else begin
            m_cnt++;
        end
        m_mode = mode;
    end

    always @(negedge clk) begin
        if (model_on)
            check("model", {22'd0, led, tick, wrap}, {22'd0, 8'(m_led), m_tick, m_wrap});
    end

    task automatic expect_step(input string name, input logic [7:0] e_led, input logic e_tick, input logic e_wrap);
        @(negedge clk);
        check(name, {22'd0, led, tick, wrap}, {22'd0, e_led, e_tick, e_wrap});
    endtask

    logic [7:0] rot_l [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] rot_r [8]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] pp    [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] fill  [15] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F,
                               8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h03};
    logic [7:0] jn    [16] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                               8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b1; div = '0; load = 1'b0; load_val = '0;
        expect_step("reset_0", 8'h01, 1'b0, 1'b0);
        expect_step("reset_1", 8'h01, 1'b0, 1'b0);

        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) expect_step("rotate_left", rot_l[i], 1'b1, i == 7);
        dir = 1'b0;
        for (int i = 0; i < 8; i++) expect_step("rotate_right", rot_r[i], 1'b1, i == 0);

        dir = 1'b1; div = 24'd3;
        repeat (3) expect_step("presc_wait", 8'h01, 1'b0, 1'b0);
        expect_step("presc_step", 8'h02, 1'b1, 1'b0);
        repeat (3) expect_step("presc_wait", 8'h02, 1'b0, 1'b0);
        expect_step("presc_step", 8'h04, 1'b1, 1'b0);
        en = 1'b0;
        repeat (2) expect_step("en_low", 8'h04, 1'b0, 1'b0);
        en = 1'b1;
        repeat (3) expect_step("en_rise_wait", 8'h04, 1'b0, 1'b0);
        expect_step("en_rise_step", 8'h08, 1'b1, 1'b0);
        repeat (2) expect_step("cnt_climb", 8'h08, 1'b0, 1'b0);
        div = 24'd1;
        expect_step("div_lowered", 8'h10, 1'b1, 1'b0);

        div = '0; mode = 2'b01;
        expect_step("pp_seed", 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) expect_step("pingpong", pp[i], 1'b1, (i == 6) || (i == 13));
        mode = 2'b00;
        expect_step("pp_abort", 8'h01, 1'b0, 1'b0);

        mode = 2'b10;
        expect_step("fill_seed", 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) expect_step("fill", fill[i], 1'b1, (i == 6) || (i == 13));

        rst = 1'b1; mode = 2'b11; dir = 1'b1;
        expect_step("jn_reset", 8'h01, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) expect_step("johnson_left", jn[i], 1'b1, i == 14);

        mode = 2'b00; div = 24'd2;
        expect_step("ld_mode", 8'h01, 1'b0, 1'b0);
        repeat (2) expect_step("ld_count", 8'h01, 1'b0, 1'b0);
        load = 1'b1; load_val = 8'hA5;
        expect_step("load_over_step", 8'hA5, 1'b0, 1'b0);
        load = 1'b0;
        repeat (2) expect_step("load_cnt_cleared", 8'hA5, 1'b0, 1'b0);
        expect_step("loaded_rotate", 8'h4B, 1'b1, 1'b1);

        rst = 1'b1; load = 1'b1; load_val = 8'h5A;
        expect_step("rst_over_load", 8'h01, 1'b0, 1'b0);
        rst = 1'b0; load_val = 8'h00; div = '0;
        expect_step("load_zero", 8'h00, 1'b0, 1'b0);
        load = 1'b0;
        repeat (3) expect_step("zero_hold", 8'h00, 1'b1, 1'b0);

        en = 1'b0; load = 1'b1; load_val = 8'h3C;
        expect_step("load_en_low", 8'h3C, 1'b0, 1'b0);
        load = 1'b0;
        expect_step("load_en_low_hold", 8'h3C, 1'b0, 1'b0);

        en = 1'b1; mode = 2'b11; dir = 1'b0;
        expect_step("jn_seed", 8'h01, 1'b0, 1'b0);
        expect_step("johnson_right", 8'h00, 1'b1, 1'b1);
        expect_step("johnson_right", 8'h80, 1'b1, 1'b0);
        expect_step("johnson_right", 8'hC0, 1'b1, 1'b0);

        mode = 2'b01;
        expect_step("pp2_seed", 8'h01, 1'b0, 1'b0);
        expect_step("pp2_step", 8'h02, 1'b1, 1'b0);
        expect_step("pp2_step", 8'h04, 1'b1, 1'b0);
        rst = 1'b1;
        expect_step("rst_mid_bounce", 8'h01, 1'b0, 1'b0);
        rst = 1'b0;
        expect_step("after_rst_step", 8'h02, 1'b1, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
